// File: rtl/player_move.sv
// Player position owner: turns single-cell move requests into wall-checked
// steps of a 4x4 footprint on the 40x40 stage map.
module player_move #(
  parameter logic [5:0] START_X = 6'd1,
  parameter logic [5:0] START_Y = 6'd1,
  parameter logic [3:0] STAGE1  = 4'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       move_req,
  input  logic [1:0] dir,
  output logic [5:0] cell_x,
  output logic [5:0] cell_y,
  input  logic       cell_wall,
  output logic [5:0] player_x,
  output logic [5:0] player_y,
  output logic       busy,
  output logic       moved_pulse,
  output logic       blocked_pulse,
  output logic       exit_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } fsm_t;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;
  localparam logic [5:0] MAXP  = 6'd36;

  fsm_t       fsm, fsm_n;
  logic [1:0] dir_q, dir_n;
  logic [1:0] k, k_n;
  logic       hit, hit_n;
  logic       ext, ext_n;
  logic [5:0] px_n, py_n;
  logic [5:0] cx_n, cy_n;
  logic       busy_n;
  logic       mv_n, bl_n, ex_n;
  logic [3:0] prev_state;
  logic       stage_on;
  logic       entry;
  logic       accept;

  assign stage_on = (state == STAGE1);
  assign entry    = stage_on && (prev_state != STAGE1);
  assign accept   = (fsm == IDLE) && stage_on && move_req;

  function automatic logic at_edge(
    input logic [1:0] d,
    input logic [5:0] x,
    input logic [5:0] y
  );
    logic r;
    r = 1'b0;
    unique case (d)
      UP:    r = (y == 6'd0);
      DOWN:  r = (y == MAXP);
      LEFT:  r = (x == 6'd0);
      RIGHT: r = (x == MAXP);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Leading-edge cell k for a move in direction d.
  function automatic logic [11:0] lead(
    input logic [1:0] d,
    input logic [5:0] x,
    input logic [5:0] y,
    input logic [1:0] kk
  );
    logic [5:0] lx, ly, ko;
    ko = {4'd0, kk};
    lx = x;
    ly = y;
    unique case (d)
      UP: begin
        lx = x + ko;
        ly = y - 6'd1;
      end
      DOWN: begin
        lx = x + ko;
        ly = y + 6'd4;
      end
      LEFT: begin
        lx = x - 6'd1;
        ly = y + ko;
      end
      RIGHT: begin
        lx = x + 6'd4;
        ly = y + ko;
      end
      default: begin
        lx = x;
        ly = y;
      end
    endcase
    return {lx, ly};
  endfunction

  always_comb begin
    fsm_n = fsm;
    dir_n = dir_q;
    k_n   = k;
    hit_n = hit;
    ext_n = ext;
    px_n  = player_x;
    py_n  = player_y;
    mv_n  = 1'b0;
    bl_n  = 1'b0;
    ex_n  = 1'b0;
    if (entry) begin
      fsm_n = IDLE;
      px_n  = START_X;
      py_n  = START_Y;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (accept) begin
            dir_n = dir;
            hit_n = 1'b0;
            k_n   = 2'd0;
            ext_n = at_edge(dir, player_x, player_y);
            if (ext_n) begin
              fsm_n = DONE;
              ex_n  = 1'b1;
            end else begin
              fsm_n = CHECK;
            end
          end
        end
        CHECK: begin
          if (!stage_on) begin
            fsm_n = IDLE;
          end else begin
            hit_n = hit | cell_wall;
            if (k == 2'd3) begin
              fsm_n = DONE;
              if (hit_n) begin
                bl_n = 1'b1;
              end else begin
                mv_n = 1'b1;
                unique case (dir_q)
                  UP:    py_n = player_y - 6'd1;
                  DOWN:  py_n = player_y + 6'd1;
                  LEFT:  px_n = player_x - 6'd1;
                  RIGHT: px_n = player_x + 6'd1;
                  default: px_n = player_x;
                endcase
              end
            end else begin
              k_n = k + 2'd1;
            end
          end
        end
        DONE: fsm_n = IDLE;
        default: fsm_n = IDLE;
      endcase
    end
  end

  // Lookup follows the leading edge while checking, else the player.
  always_comb begin
    cx_n = px_n;
    cy_n = py_n;
    if (fsm_n == CHECK) begin
      {cx_n, cy_n} = lead(dir_n, player_x, player_y, k_n);
    end
  end

  assign busy_n = (fsm_n != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm           <= IDLE;
      dir_q         <= 2'd0;
      k             <= 2'd0;
      hit           <= 1'b0;
      ext           <= 1'b0;
      player_x      <= START_X;
      player_y      <= START_Y;
      cell_x        <= START_X;
      cell_y        <= START_Y;
      busy          <= 1'b0;
      moved_pulse   <= 1'b0;
      blocked_pulse <= 1'b0;
      exit_pulse    <= 1'b0;
      prev_state    <= 4'd0;
    end else begin
      fsm           <= fsm_n;
      dir_q         <= dir_n;
      k             <= k_n;
      hit           <= hit_n;
      ext           <= ext_n;
      player_x      <= px_n;
      player_y      <= py_n;
      cell_x        <= cx_n;
      cell_y        <= cy_n;
      busy          <= busy_n;
      moved_pulse   <= mv_n;
      blocked_pulse <= bl_n;
      exit_pulse    <= ex_n;
      prev_state    <= state;
    end
  end

endmodule

// File: tb/tb_player_move.sv
// Directed bench for player_move: table of moves plus hand-written
// sequences for timing, abort, burst requests and async reset.
module tb_player_move;

  localparam int K_MOV = 0;
  localparam int K_BLK = 1;
  localparam int K_EXT = 2;

  logic       clk;
  logic       rst;
  logic [3:0] state;
  logic       move_req;
  logic [1:0] dir;
  logic [5:0] cell_x, cell_y;
  logic       cell_wall;
  logic [5:0] player_x, player_y;
  logic       busy;
  logic       moved_pulse, blocked_pulse, exit_pulse;
  logic       wall_on;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int oob       = 0;

  player_move dut (
    .clk(clk),
    .rst(rst),
    .state(state),
    .move_req(move_req),
    .dir(dir),
    .cell_x(cell_x),
    .cell_y(cell_y),
    .cell_wall(cell_wall),
    .player_x(player_x),
    .player_y(player_y),
    .busy(busy),
    .moved_pulse(moved_pulse),
    .blocked_pulse(blocked_pulse),
    .exit_pulse(exit_pulse)
  );

  assign cell_wall = wall_on && (cell_x == 6'd5) && (cell_y == 6'd3);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (!rst && (cell_x > 6'd39 || cell_y > 6'd39 ||
                 player_x > 6'd36 || player_y > 6'd36))
      oob++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_move(input logic [1:0] d, input int ex, input int ey,
                         input int kind, input string name);
    int nb, nm, nbl, nex;
    @(negedge clk);
    dir = d;
    move_req = 1'b1;
    @(posedge clk);
    #1;
    move_req = 1'b0;
    nb = 0; nm = 0; nbl = 0; nex = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      nb++;
      nm  += int'(moved_pulse);
      nbl += int'(blocked_pulse);
      nex += int'(exit_pulse);
      @(posedge clk);
      #1;
    end
    chk({name, " busy_cycles"}, nb, (kind == K_EXT) ? 1 : 5);
    chk({name, " moved"}, nm, (kind == K_MOV) ? 1 : 0);
    chk({name, " blocked"}, nbl, (kind == K_BLK) ? 1 : 0);
    chk({name, " exit"}, nex, (kind == K_EXT) ? 1 : 0);
    chk({name, " x"}, int'(player_x), ex);
    chk({name, " y"}, int'(player_y), ey);
  endtask

  typedef struct {
    logic [1:0] d;
    logic       wall;
    int         x;
    int         y;
    int         kind;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int nm;
    tbl[0] = '{2'd2, 1'b0, 1, 1, K_MOV};
    tbl[1] = '{2'd3, 1'b1, 1, 1, K_BLK};
    tbl[2] = '{2'd1, 1'b1, 1, 2, K_MOV};
    tbl[3] = '{2'd3, 1'b1, 1, 2, K_BLK};
    tbl[4] = '{2'd0, 1'b0, 1, 1, K_MOV};
    tbl[5] = '{2'd0, 1'b0, 1, 0, K_MOV};
    tbl[6] = '{2'd0, 1'b0, 1, 0, K_EXT};
    tbl[7] = '{2'd2, 1'b0, 0, 0, K_MOV};
    tbl[8] = '{2'd2, 1'b0, 0, 0, K_EXT};

    rst = 1'b1;
    state = 4'd2;
    move_req = 1'b0;
    dir = 2'd0;
    wall_on = 1'b0;
    #1;
    chk("rst x", int'(player_x), 1);
    chk("rst y", int'(player_y), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst cell_x", int'(cell_x), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle x", int'(player_x), 1);
    chk("idle busy", int'(busy), 0);

    // first move right on an empty map, cycle by cycle
    dir = 2'd3;
    move_req = 1'b1;
    @(posedge clk);
    #1;
    move_req = 1'b0;
    for (int kk = 0; kk < 4; kk++) begin
      chk("m1 busy", int'(busy), 1);
      chk("m1 cell_x", int'(cell_x), 5);
      chk("m1 cell_y", int'(cell_y), 1 + kk);
      chk("m1 moved early", int'(moved_pulse), 0);
      @(posedge clk);
      #1;
    end
    chk("m1 moved", int'(moved_pulse), 1);
    chk("m1 busy done", int'(busy), 1);
    chk("m1 x", int'(player_x), 2);
    chk("m1 y", int'(player_y), 1);
    @(posedge clk);
    #1;
    chk("m1 busy end", int'(busy), 0);
    chk("m1 moved end", int'(moved_pulse), 0);
    chk("m1 cell_x idle", int'(cell_x), 2);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      wall_on = tbl[i].wall;
      do_move(tbl[i].d, tbl[i].x, tbl[i].y, tbl[i].kind,
              $sformatf("tbl%0d", i));
    end
    wall_on = 1'b0;

    // leave the stage during CHECK k=2 from (0,0)
    @(negedge clk);
    dir = 2'd1;
    move_req = 1'b1;
    @(posedge clk);
    #1;
    move_req = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("ab cell_x k2", int'(cell_x), 2);
    chk("ab cell_y k2", int'(cell_y), 4);
    state = 4'd8;
    @(posedge clk);
    #1;
    chk("ab busy", int'(busy), 0);
    nm = 0;
    for (int i = 0; i < 5; i++) begin
      nm += int'(moved_pulse) + int'(blocked_pulse) + int'(exit_pulse);
      @(posedge clk);
      #1;
    end
    chk("ab pulses", nm, 0);
    chk("ab y", int'(player_y), 0);
    @(negedge clk);
    state = 4'd2;
    @(posedge clk);
    #1;
    chk("reload x", int'(player_x), 1);
    chk("reload y", int'(player_y), 1);

    // move_req held for 12 edges
    @(negedge clk);
    dir = 2'd1;
    move_req = 1'b1;
    nm = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      nm += int'(moved_pulse);
    end
    move_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
      nm += int'(moved_pulse);
    end
    chk("burst moves", nm, 2);
    chk("burst busy", int'(busy), 0);
    chk("burst y", int'(player_y), 3);

    do_move(2'd2, 0, 3, K_MOV, "walk l");
    for (int i = 0; i < 15; i++)
      do_move(2'd1, 0, 4 + i, K_MOV, "walk d");

    // exit to the left from (0,18)
    @(negedge clk);
    dir = 2'd2;
    move_req = 1'b1;
    @(posedge clk);
    #1;
    move_req = 1'b0;
    chk("ex pulse", int'(exit_pulse), 1);
    chk("ex busy", int'(busy), 1);
    chk("ex cell_x", int'(cell_x), 0);
    @(posedge clk);
    #1;
    chk("ex pulse end", int'(exit_pulse), 0);
    chk("ex busy end", int'(busy), 0);
    chk("ex x", int'(player_x), 0);
    chk("ex y", int'(player_y), 18);

    for (int i = 0; i < 36; i++)
      do_move(2'd3, i + 1, 18, K_MOV, "walk r");
    do_move(2'd3, 36, 18, K_EXT, "right edge");
    for (int i = 0; i < 26; i++)
      do_move(2'd2, 35 - i, 18, K_MOV, "back l");
    for (int i = 0; i < 8; i++)
      do_move(2'd0, 10, 17 - i, K_MOV, "back u");

    // async reset in the middle of a check
    @(negedge clk);
    dir = 2'd3;
    move_req = 1'b1;
    @(posedge clk);
    #1;
    move_req = 1'b0;
    @(posedge clk);
    #1;
    chk("ar pre busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar x", int'(player_x), 1);
    chk("ar y", int'(player_y), 1);
    chk("ar cell_x", int'(cell_x), 1);
    chk("ar cell_y", int'(cell_y), 1);
    chk("ar busy", int'(busy), 0);
    chk("ar pulses", int'(moved_pulse) + int'(blocked_pulse) +
        int'(exit_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("range", oob, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/player_move.md
# player_move

Game-logic block that owns the player position on the 40x40-cell stage map. It turns single-cell move requests into wall-checked position updates by querying an external wall lookup for the four cells on the player's leading edge. It sits beside the wall renderer: the renderer reads the map per pixel for display, and this block reads it per move for collision. Position outputs feed the player sprite renderer and the stage FSM; `exit_pulse` tells the stage FSM the player has left the grid.

## Interface
Parameters:
- `START_X`, default 1: reset/reload column of the player's top-left cell.
- `START_Y`, default 1: reset/reload row of the player's top-left cell.
- `STAGE1`, default 4'd2: game-state code in which movement is enabled.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `state`  in  4  game state code.
- `move_req`  in  1  one-cycle move request.
- `dir`  in  2  direction, sampled with `move_req`: 0 = up (y-1), 1 = down (y+1), 2 = left (x-1), 3 = right (x+1).
- `cell_x`  out  6  lookup column, registered.
- `cell_y`  out  6  lookup row, registered.
- `cell_wall`  in  1  wall bit for (`cell_x`, `cell_y`). Combinational from the map, valid in the same cycle.
- `player_x`  out  6  player top-left column, 0..36.
- `player_y`  out  6  player top-left row, 0..36.
- `busy`  out  1  high while a move is in progress.
- `moved_pulse`  out  1  one cycle high: move committed.
- `blocked_pulse`  out  1  one cycle high: move rejected by a wall.
- `exit_pulse`  out  1  one cycle high: move would leave the 40x40 grid.

## Operation
- Player footprint is 4x4 cells, covering [player_x..player_x+3] by [player_y..player_y+3].
- FSM states: IDLE, CHECK, DONE.
- IDLE
  - `cell_x`/`cell_y` track `player_x`/`player_y`.
  - `move_req` is accepted only when `state` == STAGE1. It is ignored in any other state and whenever `busy` is high.
  - On accept: latch `dir`, clear the hit flag and k, then pick the next state:
    - If the leading edge would leave the grid (up with y=0, down with y=36, left with x=0, right with x=36), go straight to DONE with the exit flag set.
    - Otherwise go to CHECK with k=0.
- CHECK, k = 0..3, one cycle each. Present the leading-edge cell and OR `cell_wall` into the hit flag:
  - up: (x+k, y-1)
  - down: (x+k, y+4)
  - left: (x-1, y+k)
  - right: (x+4, y+k)
  - After k=3, go to DONE. All 4 checks always run; there is no early exit on a wall hit.
- DONE, one cycle, outputs registered on entry:
  - exit flag set: `exit_pulse`=1, position unchanged.
  - hit flag set: `blocked_pulse`=1, position unchanged.
  - otherwise: position steps one cell in `dir`, and `moved_pulse`=1.
  - Then return to IDLE.
- Arithmetic: 6-bit unsigned. The bounds check guarantees no wrap, so all lookup coordinates stay in 0..39.
- Stage entry: in the first cycle `state` == STAGE1 while the registered previous state != STAGE1, load position to (START_X, START_Y) and force IDLE.
- Stage exit mid-move: if `state` != STAGE1 during CHECK, abort to IDLE. No position update and no pulse.
- Reset: FSM IDLE, `player_x`=START_X, `player_y`=START_Y, `cell_x`=START_X, `cell_y`=START_Y, `busy`=0, all pulses 0, previous-state register = 0.

## Timing
- `move_req` is sampled at edge E0.
- In-grid move:
  - CHECK k=0..3 occupies cycles after E0..E3.
  - DONE is entered at E4: new position and pulse are visible after E4.
  - IDLE is re-entered at E5.
  - `busy` is high from after E0 through E5, i.e. 5 cycles.
- Out-of-grid move: DONE at E0 with `exit_pulse` high for one cycle, IDLE at E1, `busy` high 1 cycle.
- `cell_x`/`cell_y` are registered. During CHECK k they hold the k-th leading-edge cell, and `cell_wall` is sampled at the end of that cycle.
- `move_req` arriving in DONE is dropped. The next accept is possible at the edge after DONE.
- Pulses are mutually exclusive. Each is high for exactly one cycle per accepted move.

## Test plan
- Reset with `state`=STAGE1 and an empty bench map: outputs at (1,1), `busy`=0; then `move_req` with dir=3 -> `busy` high 5 cycles, `cell_x`=5 with `cell_y` stepping 1,2,3,4, then (2,1) and `moved_pulse` once.
- Bench map wall at (5,3), player at (1,1), dir=3 -> `blocked_pulse` once and position stays (1,1); repeat with dir=1 -> moves to (1,2).
- Player at (0,18), dir=2 -> `exit_pulse` at E0, `busy` high 1 cycle, position stays (0,18), `cell_x`/`cell_y` never go out of range.
- `move_req` pulses every cycle for 12 cycles with dir=1 on an empty map from (1,1) -> exactly 2 moves accepted, position (1,3).
- Change `state` to 4'd8 during CHECK k=2 -> FSM returns to IDLE, no pulse, position unchanged; return to STAGE1 -> position reloads to (1,1).
- Assert `rst` during CHECK with position (10,10) -> all outputs return to reset values immediately, without waiting for a clock edge.
